mu0_ram_arbiter: RTL and testbench
==================================

# mu0_ram_arbiter

Two-port arbiter that shares the single-port, one-cycle-read-latency 16x4096 RAM between two bus masters: the MU0 CPU-side memory decoder (master 0) and a second requester such as a loader, DMA or debug port (master 1). It grants one access per cycle using round-robin ownership with a bounded burst length. It routes read data back to the issuing master one cycle after acceptance. It sits between the masters and the RAM instance in the top-level bench and system.

## Interface
Parameters:
- ADDR_W, 12, word-address width.
- DATA_W, 16, data width.
- BURST_LEN, 4, maximum consecutive accepted accesses by the owner while the other master waits; legal range 1..15.

Ports (i = 0, 1):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- m{i}_address  in  ADDR_W  request address.
- m{i}_read  in  1  read request.
- m{i}_write  in  1  write request.
- m{i}_writedata  in  DATA_W  write data.
- m{i}_wait  out  1  high means the request is not accepted this cycle; the master must hold it stable.
- m{i}_readdata  out  DATA_W  read return data; valid only when m{i}_readvalid is high.
- m{i}_readvalid  out  1  one-cycle strobe for returned read data.
- ram_address  out  ADDR_W  to RAM.
- ram_read  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DATA_W  to RAM.
- ram_readdata  in  DATA_W  from RAM; valid the cycle after ram_read is accepted.

## Operation
- req_i = m{i}_read | m{i}_write.
- If m{i}_read and m{i}_write are both high, the write takes precedence. The read is dropped and no readvalid is generated.
- States:
  - IDLE: no owner.
  - OWN0: master 0 owns the RAM.
  - OWN1: master 1 owns the RAM.
- Registered state: owner, burst count cnt (4 bit, saturating at BURST_LEN), prio bit (preferred master from IDLE, reset 0), pending-read owner, and pending-read flag.
- Grant is combinational from state and requests, so handover costs no idle cycle:
  - IDLE: grant the sole requester. If both request, grant master prio.
  - OWNi: grant i if req_i and (cnt < BURST_LEN or !req_j). Otherwise grant j if req_j.
  - No requests: no grant.
- The granted master sees m{i}_wait = 0. Its request is driven onto the ram_* outputs. The other master sees wait = 1 while requesting, and 0 while not requesting.
- With no grant, ram_read = ram_write = 0. ram_address and ram_writedata then hold master 0's values, which are don't-care.
- On posedge with grant g:
  - owner <= g.
  - cnt <= 1 if g differs from the previous owner, otherwise min(cnt+1, BURST_LEN).
  - prio <= !g.
- With no grant: state <= IDLE, cnt <= 0, and prio is kept.
- A read accepted at posedge t sets the pending flag, tagged with g. In cycle t+1, m{g}_readvalid = 1 and m{g}_readdata = ram_readdata. The other master's readvalid is 0.
- m{i}_readdata outputs ram_readdata unconditionally; only readvalid qualifies it.

## Timing
- Accept-to-readvalid latency is 1 cycle.
- Back-to-back reads are accepted every cycle, from the same or alternating masters, with readvalid streaming 1 cycle behind.
- A write completes at the accepting edge. A read of the same address in the next cycle returns the new data.
- Under continuous contention, the owner gets exactly BURST_LEN accesses, then the other master gets BURST_LEN, and so on.
- Reset values: state IDLE, cnt 0, prio 0, pending flag 0.
- While rst is high: ram_read = ram_write = 0, both m{i}_wait = 1, both m{i}_readvalid = 0.
- Reset asserted mid-operation discards an in-flight read, so no readvalid follows. The first cycle after reset behaves as IDLE with prio 0.

## Structure
- Package mu0_mem_pkg holds ADDR_W and DATA_W defaults and the owner_t enum {IDLE, OWN0, OWN1}. The RAM wrapper and decoder share it.
- No sub-module: the design is a single module with a combinational grant/mux block, a state/counter register block, and a read-return register.

## Test plan
- Master 0 reads 0x010 alone, with the RAM preloaded to 0xBEEF there -> wait = 0, m0_readvalid high exactly 1 cycle later with 0xBEEF, m1_readvalid stays 0.
- Both masters issue reads in the first cycle after reset -> master 0 is granted first. With continuous requests and BURST_LEN = 4 the grant sequence is 0,0,0,0,1,1,1,1,0, with each readvalid on the correct port.
- Master 1 writes 0x1234 to 0x0FF while master 0 is idle, then master 0 reads 0x0FF the next cycle -> m0_readdata = 0x1234.
- Master 0 stops requesting after 2 accesses while master 1 waits -> master 1 is granted in the very next cycle with no idle cycle, and its cnt restarts at 1.
- Master 1 asserts read and write together at 0x020 with data 0x5555 -> a single write is performed, m1_readvalid never fires, and a later read returns 0x5555.
- rst pulses in the cycle after master 0's read is accepted -> no m0_readvalid, both waits are 1 during reset, and after reset master 0 wins a simultaneous request.

Source files
------------

// File: rtl/mu0_mem_pkg.sv
// Shared memory-subsystem definitions for the MU0 RAM, its decoder and the arbiter.
package mu0_mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

endpackage

// File: rtl/mu0_ram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port RAM between two masters.
// Grant is combinational so ownership handover costs no idle cycle.
module mu0_ram_arbiter
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_wait,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readvalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_wait,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readvalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef logic [3:0] cnt_t;
    localparam cnt_t BURST_MAX = cnt_t'(BURST_LEN);

    owner_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   prio_q, prio_d;
    logic   pend_q, pend_d;
    logic   pend_own_q, pend_own_d;

    logic   req0, req1;
    logic   gnt_v, gnt_sel;
    logic   sel_rd, sel_wr;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt_v   = 1'b0;
        gnt_sel = 1'b0;
        if (!rst) begin
            case (state_q)
                OWN0: begin
                    if (req0 && ((cnt_q < BURST_MAX) || !req1)) begin
                        gnt_v = 1'b1;
                    end else if (req1) begin
                        gnt_v   = 1'b1;
                        gnt_sel = 1'b1;
                    end
                end
                OWN1: begin
                    if (req1 && ((cnt_q < BURST_MAX) || !req0)) begin
                        gnt_v   = 1'b1;
                        gnt_sel = 1'b1;
                    end else if (req0) begin
                        gnt_v = 1'b1;
                    end
                end
                default: begin
                    if (req0 && req1) begin
                        gnt_v   = 1'b1;
                        gnt_sel = prio_q;
                    end else if (req0 || req1) begin
                        gnt_v   = 1'b1;
                        gnt_sel = ~req0;
                    end
                end
            endcase
        end
    end

    // Without a grant gnt_sel is 0, so the RAM bus idles on master 0's values.
    assign ram_address   = gnt_sel ? m1_address   : m0_address;
    assign ram_writedata = gnt_sel ? m1_writedata : m0_writedata;
    assign sel_wr        = gnt_sel ? m1_write     : m0_write;
    assign sel_rd        = gnt_sel ? m1_read      : m0_read;
    assign ram_write     = gnt_v & sel_wr;
    assign ram_read      = gnt_v & sel_rd & ~sel_wr;

    assign m0_wait = rst | (req0 & ~(gnt_v & ~gnt_sel));
    assign m1_wait = rst | (req1 & ~(gnt_v &  gnt_sel));

    always_comb begin
        state_d    = IDLE;
        cnt_d      = '0;
        prio_d     = prio_q;
        pend_d     = ram_read;
        pend_own_d = gnt_sel;
        if (gnt_v) begin
            state_d = gnt_sel ? OWN1 : OWN0;
            prio_d  = ~gnt_sel;
            if (state_d != state_q) begin
                cnt_d = cnt_t'(1);
            end else if (cnt_q >= BURST_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_own_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            pend_q     <= pend_d;
            pend_own_q <= pend_own_d;
        end
    end

    assign m0_readdata  = ram_readdata;
    assign m1_readdata  = ram_readdata;
    assign m0_readvalid = ~rst & pend_q & ~pend_own_q;
    assign m1_readvalid = ~rst & pend_q &  pend_own_q;

endmodule

// File: tb/tb_mu0_ram_arbiter.sv
// Self-checking bench for mu0_ram_arbiter: directed scenarios plus a randomized run
// against a behavioural arbitration/memory model.
module tb_mu0_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic          m0_wait, m1_wait, m0_readvalid, m1_readvalid;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic [AW-1:0] ram_address;
    logic          ram_read, ram_write;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_readdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mu0_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_wait(m0_wait), .m0_readdata(m0_readdata),
        .m0_readvalid(m0_readvalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_wait(m1_wait), .m1_readdata(m1_readdata),
        .m1_readvalid(m1_readvalid),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    // RAM instance stand-in: one-cycle read latency, plus a preload port.
    logic [DW-1:0] mem [4096];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_write) mem[ram_address] <= ram_writedata;
        if (ram_read) ram_readdata <= mem[ram_address];
    end

    // Reference model: who holds the RAM, how long they've held it, who is preferred.
    logic [DW-1:0] mdl_mem [4096];
    int            m_owner = -1;
    int            m_run   = 0;
    int            m_pref  = 0;
    bit            m_pv [2];
    logic [DW-1:0] m_pdata = '0;

    bit            c_rst;
    bit            c_rd [2];
    bit            c_wr [2];
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_wd [2];
    bit            e_gv, e_w0, e_w1, e_rv0, e_rv1, e_ram_rd, e_ram_wr;
    int            e_g;
    logic [DW-1:0] e_rdata;

    task automatic model_eval();
        bit r0, r1;
        c_rst = rst;
        c_rd[0] = m0_read;  c_wr[0] = m0_write; c_addr[0] = m0_address; c_wd[0] = m0_writedata;
        c_rd[1] = m1_read;  c_wr[1] = m1_write; c_addr[1] = m1_address; c_wd[1] = m1_writedata;
        r0 = c_rd[0] | c_wr[0];
        r1 = c_rd[1] | c_wr[1];
        e_gv = 1'b0;
        e_g  = 0;
        if (!c_rst && (r0 || r1)) begin
            e_gv = 1'b1;
            if (r0 && !r1)      e_g = 0;
            else if (r1 && !r0) e_g = 1;
            else if (m_owner < 0) e_g = m_pref;
            else if (m_run >= BL) e_g = 1 - m_owner;
            else                  e_g = m_owner;
        end
        e_w0     = c_rst || (r0 && !(e_gv && e_g == 0));
        e_w1     = c_rst || (r1 && !(e_gv && e_g == 1));
        e_ram_wr = e_gv && c_wr[e_g];
        e_ram_rd = e_gv && c_rd[e_g] && !c_wr[e_g];
        e_rv0    = !c_rst && m_pv[0];
        e_rv1    = !c_rst && m_pv[1];
        e_rdata  = m_pdata;
    endtask

    task automatic model_commit();
        m_pv[0] = 1'b0;
        m_pv[1] = 1'b0;
        if (c_rst) begin
            m_owner = -1; m_run = 0; m_pref = 0;
        end else if (e_gv) begin
            if (c_wr[e_g]) begin
                mdl_mem[c_addr[e_g]] = c_wd[e_g];
            end else begin
                m_pv[e_g] = 1'b1;
                m_pdata   = mdl_mem[c_addr[e_g]];
            end
            m_run   = (e_g == m_owner) ? m_run + 1 : 1;
            m_owner = e_g;
            m_pref  = 1 - e_g;
        end else begin
            m_owner = -1; m_run = 0;
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_eval();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_m0(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    endtask

    task automatic set_m1(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    endtask

    task automatic idle_cycles(input int n);
        set_m0(0, 0, '0, '0);
        set_m1(0, 0, '0, '0);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic do_reset();
        set_m0(0, 0, '0, '0);
        set_m1(0, 0, '0, '0);
        rst = 1'b1;
        cyc_begin();
        cyc_end();
        rst = 1'b0;
    endtask

    task automatic preload();
        logic [DW-1:0] d;
        for (int a = 0; a < 64; a++) begin
            d = (a == 16) ? 16'hBEEF : DW'($urandom);
            pre_we = 1'b1; pre_addr = AW'(a); pre_data = d;
            mdl_mem[a] = d;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_m0(1, 0, 12'h001, '0);
        set_m1(0, 1, 12'h002, 16'h0F0F);
        cyc_begin();
        n_checks++;
        if (m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
            n_fail++; $display("FAIL reset_wait: got %b%b exp 11", m0_wait, m1_wait);
        end
        n_checks++;
        if (ram_read !== 1'b0 || ram_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_ram_ctl: got rd=%b wr=%b exp 0 0", ram_read, ram_write);
        end
        n_checks++;
        if (m0_readvalid !== 1'b0 || m1_readvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_readvalid: got %b%b exp 00", m0_readvalid, m1_readvalid);
        end
        cyc_end();
        do_reset();
    endtask

    task automatic test_single_read();
        set_m0(1, 0, 12'h010, '0);
        cyc_begin();
        n_checks++;
        if (m0_wait !== 1'b0 || ram_read !== 1'b1 || ram_address !== 12'h010) begin
            n_fail++;
            $display("FAIL single_grant: got wait=%b rd=%b addr=%h exp 0 1 010", m0_wait, ram_read, ram_address);
        end
        cyc_end();
        set_m0(0, 0, '0, '0);
        cyc_begin();
        n_checks++;
        if (m0_readvalid !== 1'b1 || m0_readdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_readdata: got rv=%b data=%h exp 1 beef", m0_readvalid, m0_readdata);
        end
        n_checks++;
        if (m1_readvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_other_rv: got %b exp 0", m1_readvalid);
        end
        cyc_end();
        cyc_begin();
        n_checks++;
        if (m0_readvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_rv_strobe: got %b exp 0", m0_readvalid);
        end
        cyc_end();
    endtask

    task automatic test_contention();
        int            seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        int            g;
        logic [AW-1:0] a0 = 12'h000, a1 = 12'h020;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            set_m0(1, 0, a0, '0);
            set_m1(1, 0, a1, '0);
            cyc_begin();
            g = (!m0_wait) ? 0 : ((!m1_wait) ? 1 : 2);
            n_checks++;
            if (g !== seq[k]) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %0d exp %0d", k, g, seq[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (m0_readvalid !== (seq[k-1] == 0) || m1_readvalid !== (seq[k-1] == 1)) begin
                    n_fail++;
                    $display("FAIL contention_rv[%0d]: got %b%b exp prev grant %0d", k, m0_readvalid, m1_readvalid, seq[k-1]);
                end
                n_checks++;
                if ((m0_readvalid || m1_readvalid) && m0_readdata !== e_rdata) begin
                    n_fail++; $display("FAIL contention_data[%0d]: got %h exp %h", k, m0_readdata, e_rdata);
                end
            end
            cyc_end();
            if (g == 0) a0 = a0 + 12'd1;
            if (g == 1) a1 = a1 + 12'd1;
        end
        idle_cycles(2);
    endtask

    task automatic test_write_then_read();
        set_m1(0, 1, 12'h0FF, 16'h1234);
        cyc_begin();
        n_checks++;
        if (m1_wait !== 1'b0 || ram_write !== 1'b1 || ram_writedata !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_grant: got wait=%b wr=%b wd=%h exp 0 1 1234", m1_wait, ram_write, ram_writedata);
        end
        cyc_end();
        set_m1(0, 0, '0, '0);
        set_m0(1, 0, 12'h0FF, '0);
        cyc_begin();
        cyc_end();
        set_m0(0, 0, '0, '0);
        cyc_begin();
        n_checks++;
        if (m0_readvalid !== 1'b1 || m0_readdata !== 16'h1234) begin
            n_fail++; $display("FAIL wr_then_rd: got rv=%b data=%h exp 1 1234", m0_readvalid, m0_readdata);
        end
        cyc_end();
    endtask

    task automatic test_handover();
        int exp_g [7] = '{0, 0, 1, 1, 1, 1, 0};
        int g;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 2) set_m0(0, 0, '0, '0);
            else        set_m0(1, 0, 12'h030, '0);
            set_m1(1, 0, 12'h031, '0);
            cyc_begin();
            g = (!m0_wait && (m0_read || m0_write)) ? 0 : ((!m1_wait) ? 1 : 2);
            n_checks++;
            if (g !== exp_g[k]) begin
                n_fail++; $display("FAIL handover_grant[%0d]: got %0d exp %0d", k, g, exp_g[k]);
            end
            cyc_end();
        end
        idle_cycles(2);
    endtask

    task automatic test_rw_both();
        set_m1(1, 1, 12'h020, 16'h5555);
        cyc_begin();
        n_checks++;
        if (ram_write !== 1'b1 || ram_read !== 1'b0 || ram_address !== 12'h020) begin
            n_fail++;
            $display("FAIL rw_both_ctl: got wr=%b rd=%b addr=%h exp 1 0 020", ram_write, ram_read, ram_address);
        end
        cyc_end();
        set_m1(0, 0, '0, '0);
        cyc_begin();
        n_checks++;
        if (m1_readvalid !== 1'b0) begin
            n_fail++; $display("FAIL rw_both_no_rv: got %b exp 0", m1_readvalid);
        end
        cyc_end();
        set_m1(1, 0, 12'h020, '0);
        cyc_begin();
        cyc_end();
        set_m1(0, 0, '0, '0);
        cyc_begin();
        n_checks++;
        if (m1_readvalid !== 1'b1 || m1_readdata !== 16'h5555) begin
            n_fail++; $display("FAIL rw_both_readback: got rv=%b data=%h exp 1 5555", m1_readvalid, m1_readdata);
        end
        cyc_end();
    endtask

    task automatic test_reset_midflight();
        idle_cycles(1);
        set_m0(1, 0, 12'h010, '0);
        cyc_begin();
        cyc_end();
        rst = 1'b1;
        set_m1(1, 0, 12'h011, '0);
        cyc_begin();
        n_checks++;
        if (m0_readvalid !== 1'b0) begin
            n_fail++; $display("FAIL midflight_rv: got %b exp 0", m0_readvalid);
        end
        n_checks++;
        if (m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
            n_fail++; $display("FAIL midflight_wait: got %b%b exp 11", m0_wait, m1_wait);
        end
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        n_checks++;
        if (m0_wait !== 1'b0 || m1_wait !== 1'b1) begin
            n_fail++; $display("FAIL midflight_prio: got %b%b exp 01", m0_wait, m1_wait);
        end
        cyc_end();
        idle_cycles(2);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (!(m0_wait && (m0_read || m0_write)))
                set_m0($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       AW'($urandom_range(0, 63)), DW'($urandom));
            if (!(m1_wait && (m1_read || m1_write)))
                set_m1($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       AW'($urandom_range(0, 63)), DW'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            cyc_begin();
            n_checks++;
            if (m0_wait !== e_w0 || m1_wait !== e_w1) begin
                n_fail++; $display("FAIL rand_wait[%0d]: got %b%b exp %b%b", k, m0_wait, m1_wait, e_w0, e_w1);
            end
            n_checks++;
            if (ram_read !== e_ram_rd || ram_write !== e_ram_wr) begin
                n_fail++;
                $display("FAIL rand_ram_ctl[%0d]: got rd=%b wr=%b exp %b %b", k, ram_read, ram_write, e_ram_rd, e_ram_wr);
            end
            if (e_gv) begin
                n_checks++;
                if (ram_address !== c_addr[e_g] || (e_ram_wr && ram_writedata !== c_wd[e_g])) begin
                    n_fail++;
                    $display("FAIL rand_ram_bus[%0d]: got %h/%h exp %h/%h", k, ram_address, ram_writedata, c_addr[e_g], c_wd[e_g]);
                end
            end
            n_checks++;
            if (m0_readvalid !== e_rv0 || m1_readvalid !== e_rv1) begin
                n_fail++; $display("FAIL rand_rv[%0d]: got %b%b exp %b%b", k, m0_readvalid, m1_readvalid, e_rv0, e_rv1);
            end
            if (e_rv0 || e_rv1) begin
                n_checks++;
                if ((e_rv0 && m0_readdata !== e_rdata) || (e_rv1 && m1_readdata !== e_rdata)) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %h/%h exp %h", k, m0_readdata, m1_readdata, e_rdata);
                end
            end
            cyc_end();
        end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mdl_mem[a] = '0;
        #1;
        preload();
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_handover();
        test_rw_both();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
